cache_ctrl_fsm: RTL and testbench

CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

---
 rtl/cache_ctrl_fsm.sv | 136 +++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_fsm.sv
// Cache controller sequencer: tag check, line fill, write-through or
// write-back with dirty-victim eviction, and a one-cycle completion pulse.
//
// state   | meaning
// IDLE    | waiting for a CPU request
// RD_TAG  | read: tag/valid/dirty lookup
// RD_FILL | read miss: fetch line from memory
// RD_DONE | read complete, data from cache
// WR_TAG  | write: tag/valid/dirty lookup
// WR_HIT  | write CPU data into the line
// WR_FILL | write-allocate: fetch line from memory
// WR_MEM  | write-through to memory
// WR_DONE | write complete
// EVICT   | write dirty victim line back to memory
module cache_ctrl_fsm #(
  parameter int MEM_LAT = 4,
  parameter int WB      = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic Strobe,
  input  logic RW,
  input  logic M,
  input  logic V,
  input  logic D,
  output logic Rdy,
  output logic W,
  output logic WSel,
  output logic RSel,
  output logic MStrobe,
  output logic MRW,
  output logic ASel,
  output logic DSet
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LOAD = CW'(MEM_LAT - 1);
  localparam logic WB_EN = (WB != 0);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_TAG  = 4'd1,
    RD_FILL = 4'd2,
    RD_DONE = 4'd3,
    WR_TAG  = 4'd4,
    WR_HIT  = 4'd5,
    WR_FILL = 4'd6,
    WR_MEM  = 4'd7,
    WR_DONE = 4'd8,
    EVICT   = 4'd9
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          rw_q;
  logic [7:0]    outs_q;

  function automatic logic is_wait(input state_t st);
    return (st == RD_FILL) || (st == WR_FILL) || (st == WR_MEM) || (st == EVICT);
  endfunction

  // Output bundle: {Rdy, W, WSel, RSel, MStrobe, MRW, ASel, DSet}
  function automatic logic [7:0] decode(input state_t st, input logic [CW-1:0] c);
    logic [7:0] o;
    o = 8'h00;
    case (st)
      RD_FILL, WR_FILL: begin
        o[3] = 1'b1;
        if (c == '0) begin
          o[6] = 1'b1;
          o[5] = 1'b1;
        end
      end
      WR_MEM:  o[3:2] = 2'b11;
      EVICT:   o[3:1] = 3'b111;
      WR_HIT: begin
        o[6] = 1'b1;
        o[0] = WB_EN;
      end
      RD_DONE: begin
        o[7] = 1'b1;
        o[4] = 1'b1;
      end
      WR_DONE: o[7] = 1'b1;
      default: o = 8'h00;
    endcase
    return o;
  endfunction

  always_comb begin
    nxt_state = state;
    nxt_cnt   = '0;
    case (state)
      IDLE:    if (Strobe) nxt_state = RW ? WR_TAG : RD_TAG;
      RD_TAG: begin
        if (M && V)               nxt_state = RD_DONE;
        else if (WB_EN && V && D) nxt_state = EVICT;
        else                      nxt_state = RD_FILL;
      end
      WR_TAG: begin
        if (M && V)      nxt_state = WR_HIT;
        else if (!WB_EN) nxt_state = WR_MEM;
        else if (V && D) nxt_state = EVICT;
        else             nxt_state = WR_FILL;
      end
      RD_FILL: if (cnt == '0) nxt_state = RD_DONE;
      WR_FILL: if (cnt == '0) nxt_state = WR_HIT;
      WR_MEM:  if (cnt == '0) nxt_state = WR_DONE;
      EVICT:   if (cnt == '0) nxt_state = rw_q ? WR_FILL : RD_FILL;
      WR_HIT:  nxt_state = WB_EN ? WR_DONE : WR_MEM;
      RD_DONE, WR_DONE: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    // EVICT->fill is a state change, so the fill reloads the full latency
    if (is_wait(nxt_state))
      nxt_cnt = (nxt_state != state) ? LOAD : cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rw_q   <= 1'b0;
      outs_q <= 8'h00;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      outs_q <= decode(nxt_state, nxt_cnt);
      if (state == IDLE && Strobe)
        rw_q <= RW;
    end
  end

  assign {Rdy, W, WSel, RSel, MStrobe, MRW, ASel, DSet} = outs_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm: three parameterisations, per-transaction
// latency and output-activity profiles against hand-computed values.
module tb_cache_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] strobe = 3'b000;
  logic       rw = 1'b0, m = 1'b0, v = 1'b0, d = 1'b0;
  wire  [7:0] o0, o1, o2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // o = {Rdy, W, WSel, RSel, MStrobe, MRW, ASel, DSet}
  cache_ctrl_fsm #(.MEM_LAT(4), .WB(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .Strobe(strobe[0]), .RW(rw), .M(m), .V(v), .D(d),
    .Rdy(o0[7]), .W(o0[6]), .WSel(o0[5]), .RSel(o0[4]),
    .MStrobe(o0[3]), .MRW(o0[2]), .ASel(o0[1]), .DSet(o0[0]));

  cache_ctrl_fsm #(.MEM_LAT(3), .WB(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .Strobe(strobe[1]), .RW(rw), .M(m), .V(v), .D(d),
    .Rdy(o1[7]), .W(o1[6]), .WSel(o1[5]), .RSel(o1[4]),
    .MStrobe(o1[3]), .MRW(o1[2]), .ASel(o1[1]), .DSet(o1[0]));

  cache_ctrl_fsm #(.MEM_LAT(1), .WB(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .Strobe(strobe[2]), .RW(rw), .M(m), .V(v), .D(d),
    .Rdy(o2[7]), .W(o2[6]), .WSel(o2[5]), .RSel(o2[4]),
    .MStrobe(o2[3]), .MRW(o2[2]), .ASel(o2[1]), .DSet(o2[0]));

  function automatic logic [7:0] outs(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      default: return o2;
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; accept happens on the next posedge (cycle 0).
  // Cycle n is observed at the n-th negedge after the accept edge.
  task automatic run_txn(input string tag, input int k,
                         input bit t_rw, input bit t_m, input bit t_v, input bit t_d,
                         input bit hold,
                         input int e_lat, input int e_mst, input int e_mrw,
                         input int e_asel, input int e_w, input int e_wmem,
                         input int e_dset, input int e_rsel, input int e_wcyc);
    logic [7:0] o;
    int lat, n_mst, n_mrw, n_asel, n_w, n_wmem, n_dset, n_rsel, n_rdy, wcyc;
    lat = -1; n_mst = 0; n_mrw = 0; n_asel = 0; n_w = 0; n_wmem = 0;
    n_dset = 0; n_rsel = 0; n_rdy = 0; wcyc = 0;
    strobe[k] = 1'b1;
    rw = t_rw; m = t_m; v = t_v; d = t_d;
    @(posedge clk);
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      o = outs(k);
      if (c == 1 && !hold) strobe[k] = 1'b0;
      // inputs outside their sampling states must not matter
      if (c >= 2) {rw, m, v, d} = 4'($urandom);
      if (o[3]) n_mst++;
      if (o[2]) n_mrw++;
      if (o[1]) n_asel++;
      if (o[6]) begin n_w++; wcyc = c; end
      if (o[6] && o[5]) n_wmem++;
      if (o[0]) n_dset++;
      if (o[4]) n_rsel++;
      if (o[7]) lat = c;
    end
    chk({tag, ".lat"},  lat,    e_lat);
    chk({tag, ".mst"},  n_mst,  e_mst);
    chk({tag, ".mrw"},  n_mrw,  e_mrw);
    chk({tag, ".asel"}, n_asel, e_asel);
    chk({tag, ".w"},    n_w,    e_w);
    chk({tag, ".wmem"}, n_wmem, e_wmem);
    chk({tag, ".dset"}, n_dset, e_dset);
    chk({tag, ".rsel"}, n_rsel, e_rsel);
    chk({tag, ".wcyc"}, wcyc,   e_wcyc);
    @(negedge clk);
    chk({tag, ".idle"}, int'(outs(k)), 0);
  endtask

  initial begin
    int seen;
    #3;
    chk("rst.o0", int'(o0), 0);
    chk("rst.o1", int'(o1), 0);
    chk("rst.o2", int'(o2), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // WB=0, MEM_LAT=4
    //                 k rw m v d hold lat mst mrw asel w wm ds rs wcyc
    run_txn("wt_rd_hit",  0, 0,1,1,0, 0,  2, 0, 0, 0, 0, 0, 0, 1, 0);
    run_txn("wt_rd_miss", 0, 0,0,1,1, 0,  6, 4, 0, 0, 1, 1, 0, 1, 5);
    run_txn("wt_wr_hit",  0, 1,1,1,1, 0,  7, 4, 4, 0, 1, 0, 0, 0, 2);
    run_txn("wt_wr_miss", 0, 1,0,1,1, 0,  6, 4, 4, 0, 0, 0, 0, 0, 0);

    // WB=1, MEM_LAT=3
    run_txn("wb_wr_dirty", 1, 1,0,1,1, 0, 9, 6, 3, 3, 2, 1, 1, 0, 8);
    run_txn("wb_rd_dirty", 1, 0,0,1,1, 0, 8, 6, 3, 3, 1, 1, 0, 1, 7);
    run_txn("wb_wr_hit",   1, 1,1,1,1, 0, 3, 0, 0, 0, 1, 0, 1, 0, 2);
    run_txn("wb_wr_clean", 1, 1,0,1,0, 0, 6, 3, 0, 0, 2, 1, 1, 0, 5);
    run_txn("wb_rd_inval", 1, 0,1,0,1, 0, 5, 3, 0, 0, 1, 1, 0, 1, 4);

    // WB=1, MEM_LAT=1, Strobe held high across back-to-back requests
    run_txn("b2b_rd_hit",   2, 0,1,1,0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    run_txn("b2b_rd_dirty", 2, 0,0,1,1, 1, 4, 2, 1, 1, 1, 1, 0, 1, 3);
    run_txn("b2b_wr_dirty", 2, 1,0,1,1, 1, 5, 2, 1, 1, 2, 1, 1, 0, 4);
    run_txn("b2b_wr_clean", 2, 1,0,0,0, 1, 4, 1, 0, 0, 2, 1, 1, 0, 3);
    run_txn("b2b_wr_hit",   2, 1,1,1,0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 2);

    // Reset during the second RD_FILL cycle aborts with no Rdy
    strobe[0] = 1'b1;
    rw = 1'b0; m = 1'b0; v = 1'b1; d = 1'b0;
    @(posedge clk);
    @(negedge clk);
    strobe[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.pre", int'(o0), 8'h08);
    #2 reset_n = 1'b0;
    #1 chk("abort.async", int'(o0), 0);
    @(posedge clk);
    #1 chk("abort.hold", int'(o0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o0 != 8'h00) seen++;
    end
    chk("abort.quiet", seen, 0);
    run_txn("post_rd_hit", 0, 0,1,1,0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
